// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Merges memory wait states, MUL/DIV handshakes, branch redirects, halt
// requests and load-use stalls into prioritised per-stage load enables and
// flushes. It also keeps saturating stall and flush performance counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             mdu_op_ex,
    input  logic             mdu_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_start,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_BUSY = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    logic [1:0] state_reg, state_next;
    // we_next bit order: {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [4:0] we_next;
    // flush_next bit order: {if_id, id_ex, ex_mem}
    logic [2:0] flush_next;
    logic       start_next;
    logic       halted_next;
    logic       branch_flush;
    logic [1:0] cnt_inc;

    // Prioritised control decode and next-state selection.
    // A flushed stage always has its load enable set as well.
    always_comb begin
        state_next   = state_reg;
        we_next      = 5'b00000;
        flush_next   = 3'b000;
        start_next   = 1'b0;
        halted_next  = 1'b0;
        branch_flush = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_next = ST_MEM_WAIT;
                end else if (mdu_op_ex) begin
                    we_next    = 5'b00011;
                    flush_next = 3'b001;
                    start_next = 1'b1;
                    state_next = ST_MDU_BUSY;
                end else if (branch_taken) begin
                    we_next      = 5'b11111;
                    flush_next   = 3'b110;
                    branch_flush = 1'b1;
                end else if (halt_req) begin
                    we_next    = 5'b01111;
                    flush_next = 3'b110;
                    state_next = ST_HALTED;
                end else if (load_use_stall) begin
                    we_next    = 5'b00111;
                    flush_next = 3'b010;
                end else begin
                    we_next = 5'b11111;
                end
            end
            ST_MEM_WAIT: begin
                // Everything except the memory handshake is ignored while EX is held.
                if (dmem_ready) begin
                    we_next    = 5'b11111;
                    state_next = ST_RUN;
                end
            end
            ST_MDU_BUSY: begin
                // EX/MEM holds a bubble here, so dmem_req is ignored.
                if (mdu_done) begin
                    we_next    = 5'b11111;
                    state_next = ST_RUN;
                end else begin
                    we_next    = 5'b00011;
                    flush_next = 3'b001;
                end
            end
            default: begin
                // Halted: the front end is frozen and the tail drains bubbles.
                we_next     = 5'b00011;
                flush_next  = 3'b001;
                halted_next = 1'b1;
            end
        endcase
    end

    // Outputs are gated by reset so they drop to zero as soon as rst_n goes low.
    always_comb begin
        pc_we        = rst_n & we_next[4];
        if_id_we     = rst_n & we_next[3];
        id_ex_we     = rst_n & we_next[2];
        ex_mem_we    = rst_n & we_next[1];
        mem_wb_we    = rst_n & we_next[0];
        if_id_flush  = rst_n & flush_next[2];
        id_ex_flush  = rst_n & flush_next[1];
        ex_mem_flush = rst_n & flush_next[0];
        mdu_start    = rst_n & start_next;
        halted       = rst_n & halted_next;
    end

    // State register; reset always returns to RUN, which drops any pending MDU op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counter events: index 0 counts stall cycles, index 1 counts branch flushes.
    // A halted core does not count as stalled.
    assign cnt_inc = {branch_flush, (state_reg != ST_HALTED) && !we_next[4]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        // Saturating counter; a clear takes priority over an increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_count = g_cnt[0].cnt_reg;
    assign flush_count = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. It drives directed scenarios followed by
// randomized traffic. A reference model derived from the stage-control rules
// predicts the control outputs and both performance counters.
module tb_pipeline_ctrl;

    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_use_stall, branch_taken, halt_req, mdu_op_ex, mdu_done;
    logic          dmem_req, dmem_ready, cnt_clr;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, halted;
    logic [CW-1:0] stall_count, flush_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: what the pipeline is currently frozen on, plus the counter values
    bit m_mem_hold, m_mdu_hold, m_halt;
    int m_stall, m_flush;
    logic [9:0] exp_ctrl;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_stall(load_use_stall), .branch_taken(branch_taken),
        .halt_req(halt_req), .mdu_op_ex(mdu_op_ex), .mdu_done(mdu_done),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mdu_start(mdu_start), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Bit order: {pc,if_id,id_ex,ex_mem,mem_wb we, if_id,id_ex,ex_mem flush, mdu_start, halted}
    wire [9:0] ctrl_vec = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                           if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, halted};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected controls for the current model situation and inputs
    function automatic logic [9:0] model_ctrl();
        logic [9:0] v;
        if (m_halt)
            v = 10'b00011_001_01;
        else if (m_mem_hold)
            v = dmem_ready ? 10'b11111_000_00 : 10'b00000_000_00;
        else if (m_mdu_hold)
            v = mdu_done ? 10'b11111_000_00 : 10'b00011_001_00;
        else if (dmem_req && !dmem_ready) v = 10'b00000_000_00;
        else if (mdu_op_ex)               v = 10'b00011_001_10;
        else if (branch_taken)            v = 10'b11111_110_00;
        else if (halt_req)                v = 10'b01111_110_00;
        else if (load_use_stall)          v = 10'b00111_010_00;
        else                              v = 10'b11111_000_00;
        return v;
    endfunction

    // Advance the model by one rising edge, using the controls predicted for this cycle
    task automatic model_step(input logic [9:0] c);
        bit was_halt, was_run, stall_evt, flush_evt;
        was_halt  = m_halt;
        was_run   = !m_halt && !m_mem_hold && !m_mdu_hold;
        stall_evt = !was_halt && !c[9];
        flush_evt = was_run && c[4] && c[9];   // a branch flush leaves pc_we set
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (stall_evt && m_stall < MAXC) m_stall++;
            if (flush_evt && m_flush < MAXC) m_flush++;
        end
        if (m_mem_hold) begin
            if (dmem_ready) m_mem_hold = 0;
        end else if (m_mdu_hold) begin
            if (mdu_done) m_mdu_hold = 0;
        end else if (was_run) begin
            if (dmem_req && !dmem_ready) m_mem_hold = 1;
            else if (mdu_op_ex) m_mdu_hold = 1;
            else if (!branch_taken && halt_req) m_halt = 1;
        end
    endtask

    task automatic model_reset();
        m_mem_hold = 0;
        m_mdu_hold = 0;
        m_halt     = 0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    // One transaction: drive inputs on the falling edge, check the controls, then the counters after the edge
    task automatic drive_cycle(input logic [7:0] in);
        @(negedge clk);
        {load_use_stall, branch_taken, halt_req, mdu_op_ex,
         mdu_done, dmem_req, dmem_ready, cnt_clr} = in;
        #1;
        exp_ctrl = model_ctrl();
        check_val("ctrl", 32'(ctrl_vec), 32'(exp_ctrl));
        @(posedge clk);
        model_step(exp_ctrl);
        #1;
        check_val("stall_count", 32'(stall_count), 32'(m_stall));
        check_val("flush_count", 32'(flush_count), 32'(m_flush));
        $display("cyc %0d in=%b ctrl=%b stall=%0d flush=%0d", cyc, in, ctrl_vec, stall_count, flush_count);
        cyc++;
    endtask

    // Asynchronous reset pulse placed between clock edges; checked before any edge arrives
    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_ctrl", 32'(ctrl_vec), 32'd0);
        check_val("rst_stall", 32'(stall_count), 32'd0);
        check_val("rst_flush", 32'(flush_count), 32'd0);
        @(posedge clk);
        #2;
        check_val("rst_hold_ctrl", 32'(ctrl_vec), 32'd0);
        rst_n = 1'b1;
        $display("cyc %0d async reset", cyc);
    endtask

    // Input byte order: {lu, br, halt, mop, mdone, dreq, drdy, clr}
    localparam logic [7:0] I_IDLE = 8'b0000_0000;
    localparam logic [7:0] I_LU   = 8'b1000_0000;
    localparam logic [7:0] I_BR   = 8'b0100_0000;
    localparam logic [7:0] I_HALT = 8'b0010_0000;
    localparam logic [7:0] I_MOP  = 8'b0001_0000;
    localparam logic [7:0] I_DONE = 8'b0000_1000;
    localparam logic [7:0] I_DREQ = 8'b0000_0100;
    localparam logic [7:0] I_RDY  = 8'b0000_0010;
    localparam logic [7:0] I_CLR  = 8'b0000_0001;

    initial begin
        rst_n = 1'b0;
        {load_use_stall, branch_taken, halt_req, mdu_op_ex,
         mdu_done, dmem_req, dmem_ready, cnt_clr} = I_BR | I_LU;
        model_reset();
        #3;
        check_val("reset_ctrl", 32'(ctrl_vec), 32'd0);
        check_val("reset_stall", 32'(stall_count), 32'd0);
        check_val("reset_flush", 32'(flush_count), 32'd0);
        #4 rst_n = 1'b1;

        drive_cycle(I_IDLE);
        // Load-use: one stall cycle
        drive_cycle(I_LU);
        check_val("lu_stall", 32'(stall_count), 32'd1);
        drive_cycle(I_IDLE);
        // Branch over load-use
        drive_cycle(I_BR | I_LU);
        check_val("br_flush", 32'(flush_count), 32'd1);
        check_val("br_stall", 32'(stall_count), 32'd1);
        // MDU: start at T, done at T+4
        drive_cycle(I_MOP);
        drive_cycle(I_MOP | I_DREQ);
        drive_cycle(I_BR);
        drive_cycle(I_IDLE);
        drive_cycle(I_DONE);
        check_val("mdu_stall", 32'(stall_count), 32'd5);
        drive_cycle(I_DONE);      // done in RUN is ignored
        // Memory wait of 3 cycles with a branch masked during the wait
        drive_cycle(I_CLR);
        drive_cycle(I_DREQ);
        drive_cycle(I_DREQ | I_BR);
        drive_cycle(I_DREQ | I_BR);
        drive_cycle(I_DREQ | I_RDY | I_BR);
        check_val("mem_stall", 32'(stall_count), 32'd3);
        check_val("mem_noflush", 32'(flush_count), 32'd0);
        drive_cycle(I_BR);
        check_val("mem_br_after", 32'(flush_count), 32'd1);
        drive_cycle(I_DREQ | I_RDY);   // ready in the first request cycle
        // Saturation
        drive_cycle(I_CLR);
        for (int i = 0; i < 20; i++) drive_cycle(I_LU);
        check_val("sat_stall", 32'(stall_count), 32'(MAXC));
        drive_cycle(I_CLR | I_LU);
        check_val("clr_prio", 32'(stall_count), 32'd0);
        // Halt, then inputs that must all be ignored
        drive_cycle(I_HALT);
        for (int i = 0; i < 4; i++) drive_cycle(I_BR | I_MOP | I_DREQ);
        check_val("halt_flag", 32'(halted), 32'd1);
        async_reset();
        drive_cycle(I_IDLE);
        // Reset mid-MDU: a late done is ignored, no start replay
        drive_cycle(I_MOP);
        drive_cycle(I_IDLE);
        async_reset();
        drive_cycle(I_DONE);
        drive_cycle(I_IDLE);
        // Reset mid-memory wait
        drive_cycle(I_DREQ);
        async_reset();
        drive_cycle(I_RDY);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            r[7] = ($urandom_range(99) < 25);
            r[6] = ($urandom_range(99) < 20);
            r[5] = ($urandom_range(99) < 3);
            r[4] = ($urandom_range(99) < 10);
            r[3] = ($urandom_range(99) < 20);
            r[2] = ($urandom_range(99) < 30);
            r[1] = ($urandom_range(99) < 50);
            r[0] = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 3) async_reset();
            drive_cycle(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
